// File: rtl/math_add_48_arb.sv
// math_add_48_arb: round-robin arbiter sharing one 48-bit adder among NUM_REQ requesters,
// with a tag pipeline that routes each returning sum back to its owner.
module math_add_48_arb #(
    parameter int NUM_REQ     = 4,
    parameter int ADD_LATENCY = 2,
    parameter int IDX_W       = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*48-1:0] req_dina,
    input  logic [NUM_REQ*48-1:0] req_dinb,
    output logic                  add_ena,
    output logic [47:0]           add_dina,
    output logic [47:0]           add_dinb,
    input  logic [48:0]           add_dout,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [48:0]           rsp_data,
    output logic [3:0]            inflight
);
    logic [IDX_W-1:0] rr;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_any;
    logic             hs;
    logic             rsp_any;
    logic [ADD_LATENCY:0] tag_v;
    logic [IDX_W-1:0] tag_idx [ADD_LATENCY+1];
    // Scan offsets high to low so the lowest offset from rr wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[(int'(rr) + i) % NUM_REQ]) begin
                gnt_any = 1'b1;
                gnt_idx = IDX_W'((int'(rr) + i) % NUM_REQ);
            end
        end
    end
    assign hs        = ena & ~rst & gnt_any;
    assign req_ready = hs ? NUM_REQ'(1) << gnt_idx : '0;
    assign rsp_any   = ena & ~rst & tag_v[ADD_LATENCY];
    assign rsp_valid = rsp_any ? NUM_REQ'(1) << tag_idx[ADD_LATENCY] : '0;
    assign rsp_data  = add_dout;
    assign add_ena   = ena;
    always_ff @(posedge clk) begin
        if (rst) begin
            rr       <= '0;
            add_dina <= '0;
            add_dinb <= '0;
            tag_v    <= '0;
            inflight <= '0;
        end else if (ena) begin
            tag_v      <= {tag_v[ADD_LATENCY-1:0], hs};
            tag_idx[0] <= gnt_idx;
            for (int i = 1; i <= ADD_LATENCY; i++) tag_idx[i] <= tag_idx[i-1];
            inflight   <= inflight + {3'b0, hs} - {3'b0, rsp_any};
            if (hs) begin
                add_dina <= req_dina[48*gnt_idx +: 48];
                add_dinb <= req_dinb[48*gnt_idx +: 48];
                rr       <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_math_add_48_arb.sv
// tb_math_add_48_arb: directed checks of a DSP-latency and a fabric-latency arbiter,
// each driving its own behavioural adder.
module tb_math_add_48_arb;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ena = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [191:0] req_dina = '0;
    logic [191:0] req_dinb = '0;
    int tests = 0;
    int fails = 0;

    logic [3:0]  d_ready, d_rsp, f_ready, f_rsp;
    logic [3:0]  d_infl, f_infl;
    logic [48:0] d_data, f_data, d_dout, f_dout;
    logic [47:0] d_a, d_b, f_a, f_b;
    logic        d_aena, f_aena;
    logic [48:0] d_s1;

    always #5 clk = ~clk;

    math_add_48_arb #(.NUM_REQ(4), .ADD_LATENCY(2), .IDX_W(2)) u_dsp (
        .clk(clk), .rst(rst), .ena(ena), .req_valid(req_valid), .req_ready(d_ready),
        .req_dina(req_dina), .req_dinb(req_dinb), .add_ena(d_aena), .add_dina(d_a),
        .add_dinb(d_b), .add_dout(d_dout), .rsp_valid(d_rsp), .rsp_data(d_data),
        .inflight(d_infl));

    math_add_48_arb #(.NUM_REQ(4), .ADD_LATENCY(1), .IDX_W(2)) u_fab (
        .clk(clk), .rst(rst), .ena(ena), .req_valid(req_valid), .req_ready(f_ready),
        .req_dina(req_dina), .req_dinb(req_dinb), .add_ena(f_aena), .add_dina(f_a),
        .add_dinb(f_b), .add_dout(f_dout), .rsp_valid(f_rsp), .rsp_data(f_data),
        .inflight(f_infl));

    // Behavioural adders: two register stages (DSP) and one (fabric).
    always_ff @(posedge clk) begin
        if (rst) begin
            d_s1   <= '0;
            d_dout <= '0;
            f_dout <= '0;
        end else begin
            if (d_aena) begin
                d_s1   <= {1'b0, d_a} + {1'b0, d_b};
                d_dout <= d_s1;
            end
            if (f_aena) f_dout <= {1'b0, f_a} + {1'b0, f_b};
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int r, input logic [47:0] a, input logic [47:0] b);
        req_dina[48*r +: 48] = a;
        req_dinb[48*r +: 48] = b;
    endtask

    initial begin
        // Reset state
        req_valid = 4'b1111;
        tick();
        #1;
        chk("rst_ready", 64'(d_ready), 64'h0);
        chk("rst_rsp", 64'(d_rsp), 64'h0);
        tick();
        rst = 1'b0;
        req_valid = '0;
        #1;
        chk("rst_infl", 64'(d_infl), 64'h0);
        chk("rst_dina", 64'(d_a), 64'h0);

        // Single op from requester 2
        set_op(2, 48'd5, 48'd7);
        req_valid = 4'b0100;
        #1;
        chk("single_ready", 64'(d_ready), 64'h4);
        chk("single_fready", 64'(f_ready), 64'h4);
        chk("single_infl0", 64'(d_infl), 64'h0);
        tick();
        req_valid = '0;
        #1;
        chk("single_infl1", 64'(d_infl), 64'h1);
        chk("single_rsp1", 64'(d_rsp), 64'h0);
        tick();
        chk("single_infl2", 64'(d_infl), 64'h1);
        chk("single_rsp2", 64'(d_rsp), 64'h0);
        chk("fab_rsp", 64'(f_rsp), 64'h4);
        chk("fab_data", 64'(f_data), 64'd12);
        tick();
        chk("single_rsp3", 64'(d_rsp), 64'h4);
        chk("single_data", 64'(d_data), 64'd12);
        chk("single_infl3", 64'(d_infl), 64'h1);
        chk("fab_rsp_once", 64'(f_rsp), 64'h0);
        tick();
        chk("single_infl4", 64'(d_infl), 64'h0);
        chk("single_rsp4", 64'(d_rsp), 64'h0);

        // Carry out of bit 47
        set_op(0, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF);
        req_valid = 4'b0001;
        #1;
        chk("carry_ready", 64'(d_ready), 64'h1);
        tick();
        req_valid = '0;
        tick();
        tick();
        chk("carry_rsp", 64'(d_rsp), 64'h1);
        chk("carry_data", 64'(d_data), 64'h1_FFFF_FFFF_FFFE);
        tick();

        // Round-robin from a fresh pointer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int r = 0; r < 4; r++) set_op(r, 48'(r), 48'd100);
        for (int j = 0; j < 12; j++) begin
            int done;
            done = (j < 3) ? 0 : ((j - 3 > 8) ? 8 : j - 3);
            req_valid = (j < 8) ? 4'b1111 : 4'b0000;
            #1;
            chk($sformatf("rr_ready%0d", j), 64'(d_ready), (j < 8) ? 64'(4'b0001 << (j % 4)) : 64'h0);
            chk($sformatf("rr_rsp%0d", j), 64'(d_rsp),
                (j >= 3 && j < 11) ? 64'(4'b0001 << ((j - 3) % 4)) : 64'h0);
            if (j >= 3 && j < 11) chk($sformatf("rr_data%0d", j), 64'(d_data), 64'(100 + (j - 3) % 4));
            chk($sformatf("rr_infl%0d", j), 64'(d_infl), 64'(((j < 8) ? j : 8) - done));
            tick();
        end

        // Freeze: ena low for 5 cycles, starting one cycle after issue
        set_op(1, 48'd1000, 48'd2345);
        req_valid = 4'b0010;
        #1;
        chk("frz_ready", 64'(d_ready), 64'h2);
        tick();
        req_valid = '0;
        tick();
        ena = 1'b0;
        req_valid = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            #1;
            chk($sformatf("frz_rsp%0d", j), 64'(d_rsp), 64'h0);
            chk($sformatf("frz_frsp%0d", j), 64'(f_rsp), 64'h0);
            chk($sformatf("frz_ready%0d", j), 64'(d_ready), 64'h0);
            chk($sformatf("frz_infl%0d", j), 64'(d_infl), 64'h1);
            tick();
        end
        ena = 1'b1;
        req_valid = '0;
        #1;
        chk("frz_fab_rsp", 64'(f_rsp), 64'h2);
        chk("frz_fab_data", 64'(f_data), 64'd3345);
        chk("frz_dsp_early", 64'(d_rsp), 64'h0);
        tick();
        chk("frz_dsp_rsp", 64'(d_rsp), 64'h2);
        chk("frz_dsp_data", 64'(d_data), 64'd3345);
        chk("frz_fab_once", 64'(f_rsp), 64'h0);
        tick();
        chk("frz_dsp_once", 64'(d_rsp), 64'h0);
        chk("frz_infl_end", 64'(d_infl), 64'h0);

        // Reset with three ops in flight
        req_valid = 4'b1111;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 64'(d_ready), 64'h0);
        chk("mid_rst_rsp", 64'(d_rsp), 64'h0);
        chk("mid_rst_frsp", 64'(f_rsp), 64'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rr0", 64'(d_ready), 64'h1);
        chk("mid_infl", 64'(d_infl), 64'h0);
        req_valid = '0;
        for (int j = 0; j < 5; j++) begin
            #1;
            chk($sformatf("mid_rsp%0d", j), 64'(d_rsp), 64'h0);
            chk($sformatf("mid_frsp%0d", j), 64'(f_rsp), 64'h0);
            chk($sformatf("mid_infl%0d", j), 64'(d_infl), 64'h0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
